mpt_walk_mem_arbiter: RTL and testbench
=======================================

Name: mpt_walk_mem_arbiter

Overview:
Shares the single MPT-walker memory read port between NUM_REQ walking/parsing stage requesters, one per walking level, that fetch MPT entries at next_mpte_addr. It uses round-robin arbitration and tracks outstanding reads in an in-order ID FIFO. Each response is routed back to the requester that issued it. A drain FSM quiesces the port on mmpt CSR writes or fences. The block sits between the walker pipeline stages and the memory interface.

Parameters:
NUM_REQ, 4, number of requesters (walking levels); 1..8
ADDR_WIDTH, 64, request address width (XLEN)
DATA_WIDTH, 64, MPTE width returned by memory
MAX_OUTSTANDING, 4, ID FIFO depth; power of two, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  per-requester read request valid
req_ready_o  out  NUM_REQ  per-requester request accepted
req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed request addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
rsp_valid_o  out  NUM_REQ  per-requester response valid
rsp_ready_i  in  NUM_REQ  per-requester response accept
rsp_data_o  out  DATA_WIDTH  response data, shared by all requesters
rsp_error_o  out  1  response bus error, shared
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory request accept
mem_req_addr_o  out  ADDR_WIDTH  memory request address
mem_rsp_valid_i  in  1  memory response valid; responses return in order
mem_rsp_ready_o  out  1  memory response accept
mem_rsp_data_i  in  DATA_WIDTH  memory response data
mem_rsp_error_i  in  1  memory response error
drain_i  in  1  level-sensitive request to quiesce
drained_o  out  1  high in DRAINED state
spurious_rsp_o  out  1  sticky: response received with no outstanding ID

Behaviour:
- Reset values: all outputs 0; FSM = RUN; rr_ptr = 0; FIFO empty; sticky flag cleared.
- Arbitration is combinational and round-robin. The winner is the first k with req_valid_i[k], searching from rr_ptr upward and wrapping.
- Issue is allowed only when state = RUN and the FIFO is not full.
- mem_req_valid_o = issue allowed & any req_valid_i. mem_req_addr_o = winner's address.
- req_ready_o[winner] = mem_req_ready_i & issue allowed; all other bits are 0.
- On a request handshake: push the winner index into the FIFO and set rr_ptr = (winner+1) mod NUM_REQ.
- rr_ptr does not change without a handshake; a stalled winner keeps the grant. mem_req_valid_o must not drop while mem_req_ready_i is low unless drain_i or reset intervenes.
- Full check is conservative: a same-cycle pop does not free a slot for a push.
- Responses have zero-latency passthrough:
  - head = FIFO head index.
  - rsp_valid_o[head] = mem_rsp_valid_i & FIFO not empty.
  - rsp_data_o/rsp_error_o = mem inputs.
  - mem_rsp_ready_o = rsp_ready_i[head].
  - Pop on the mem response handshake.
- FIFO empty and mem_rsp_valid_i high: mem_rsp_ready_o = 1, the response is dropped, spurious_rsp_o is set and stays set until reset.
- Simultaneous push and pop: both take effect; the occupancy count is unchanged.
- FSM states:
  - RUN -> DRAINING when drain_i is high.
  - DRAINING: no new issue. -> DRAINED when the FIFO is empty, or is empty after this cycle's pop.
  - DRAINED: drained_o = 1, no issue. -> RUN when drain_i is low.
  - DRAINING -> RUN directly if drain_i falls before the FIFO empties.
- drain_i while a request is stalled: mem_req_valid_o drops next cycle. The memory side must tolerate this because drain is only used with an idle or abortable memory.
- Reset mid-operation: the FIFO is flushed. Memory must be reset together with this block; any response after reset counts as spurious.
- Widths:
  - Index width = $clog2(NUM_REQ), minimum 1.
  - Count width = $clog2(MAX_OUTSTANDING)+1.
  - Pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
MPT_ARB_PERF_CNT_EN
- Defined: adds output perf_grant_cnt_o (NUM_REQ*32, per-requester accepted-request counters) and perf_full_stall_cnt_o (32, cycles with any req_valid_i high while the FIFO is full). Counters saturate at all-ones and clear on reset.
- Undefined: these ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- mpt_pkg: arb_state_e {ARB_RUN, ARB_DRAINING, ARB_DRAINED}, constant MPT_ARB_PERF_CNT_WIDTH = 32, and a function rr_pick(valid, ptr) returning the winner index.
- Sub-module mpt_id_fifo: synchronous FIFO of requester indices with push/pop, full/empty and count; instantiated once.

Test Plan:
- Reset the block with rst_i=1 for 2 cycles -> all outputs 0, drained_o=0, FSM in RUN.
- All 4 requesters hold valid with addresses 0x1000/0x2000/0x3000/0x4000, mem_req_ready_i=1 -> grant order 0,1,2,3,0; each address appears once per rotation.
- Issue 4 requests with no memory response -> 5th request stalls (req_ready_o=0, mem_req_valid_o=0). One response returns -> issue resumes the cycle after the pop.
- Requesters 2 then 0 issue; memory returns 0xAA then 0xBB -> rsp_valid_o[2] gets 0xAA, then rsp_valid_o[0] gets 0xBB. Holding rsp_ready_i[2]=0 for 3 cycles keeps mem_rsp_ready_o=0.
- drain_i=1 with 2 reads outstanding -> no new grants. drained_o rises the cycle after the 2nd response; drain_i=0 -> RUN next cycle.
- mem_rsp_valid_i=1 with the FIFO empty -> mem_rsp_ready_o=1, no rsp_valid_o bit set, spurious_rsp_o=1 sticky until rst_i.

Source files
------------

// File: rtl/mpt_walk_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mpt_pkg
// Shared types and helpers for the MPT-walker memory-port arbiter.
//   arb_state_e             : drain FSM states
//   MPT_ARB_PERF_CNT_WIDTH  : width of the optional performance counters
//   MPT_ARB_MAX_REQ         : largest supported requester count
//   rr_pick()               : round-robin winner search
// -----------------------------------------------------------------------------
package mpt_pkg;

    typedef enum logic [1:0] {
        ARB_RUN      = 2'd0,
        ARB_DRAINING = 2'd1,
        ARB_DRAINED  = 2'd2
    } arb_state_e;

    localparam int unsigned MPT_ARB_PERF_CNT_WIDTH = 32;
    localparam int unsigned MPT_ARB_MAX_REQ        = 8;

    // First set bit of valid[num-1:0], searching upward from ptr and wrapping.
    // With no bit set the pointer itself is returned, so an idle arbiter
    // reports a stable (but meaningless) winner.
    function automatic int unsigned rr_pick(
        input logic [MPT_ARB_MAX_REQ-1:0] valid,
        input int unsigned                ptr,
        input int unsigned                num
    );
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MPT_ARB_MAX_REQ; i++) begin
            if (i < num) begin
                idx = (ptr + i) % num;
                if (!found && valid[idx[2:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mpt_walk_mem_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// mpt_id_fifo
// Synchronous in-order FIFO holding the requester index of every read that
// has been issued to memory and not yet answered.
//   clk_i, rst_i   : clock, synchronous active-high reset (flushes the FIFO)
//   push_i         : write push_data_i (ignored when full)
//   push_data_i    : requester index of the issued read
//   pop_i          : retire the head entry (ignored when empty)
//   head_o         : requester index of the oldest outstanding read
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored entries
// -----------------------------------------------------------------------------
module mpt_id_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mpt_walk_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mpt_walk_mem_arbiter
// Shares the single MPT-walker memory read port among NUM_REQ walk-level
// requesters. Round-robin arbitration on the request side, an in-order ID
// FIFO to route each response back to its issuer, and a drain FSM that
// quiesces the port for mmpt CSR writes and fences.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : per-requester read request handshake
//   req_addr_i              : packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rsp_valid_o/rsp_ready_i : per-requester response handshake
//   rsp_data_o, rsp_error_o : response payload, shared by all requesters
//   mem_req_*               : memory request channel
//   mem_rsp_*               : memory response channel (in-order)
//   drain_i                 : level request to quiesce the port
//   drained_o               : high while quiesced
//   spurious_rsp_o          : sticky, a response arrived with nothing outstanding
//
// Optional feature macro MPT_ARB_PERF_CNT_EN adds perf_grant_cnt_o (one
// saturating 32-bit accepted-request counter per requester) and
// perf_full_stall_cnt_o (cycles with any request pending while the ID FIFO
// is full).
// -----------------------------------------------------------------------------
module mpt_walk_mem_arbiter
    import mpt_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_error_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    input  logic                          mem_rsp_valid_i,
    output logic                          mem_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i,
    input  logic                          mem_rsp_error_i,
    input  logic                          drain_i,
    output logic                          drained_o,
    output logic                          spurious_rsp_o
`ifdef MPT_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*MPT_ARB_PERF_CNT_WIDTH-1:0] perf_grant_cnt_o,
    output logic [MPT_ARB_PERF_CNT_WIDTH-1:0]         perf_full_stall_cnt_o
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       spurious_q, spurious_d;

    logic [MPT_ARB_MAX_REQ-1:0] valid_pad;
    logic [IDX_W-1:0]           winner;
    logic [IDX_W-1:0]           head;
    logic                       fifo_full, fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    logic                       issue_ok;
    logic                       any_valid;
    logic                       req_hs;
    logic                       rsp_pop;
    logic                       drain_empty;

    // ---------------------------------------------------------------- request
    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_REQ-1:0] = req_valid_i;
    end

    assign any_valid = |req_valid_i;
    assign winner    = IDX_W'(rr_pick(valid_pad, 32'(rr_ptr_q), NUM_REQ));

    assign mem_req_valid_o = issue_ok & any_valid;
    // Address is forced to zero when no request is offered so the bus is
    // quiet while idle.
    assign mem_req_addr_o  = mem_req_valid_o ? req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH]
                                             : '0;
    assign req_hs          = mem_req_valid_o & mem_req_ready_i;

    always_comb begin
        req_ready_o         = '0;
        req_ready_o[winner] = mem_req_ready_i & issue_ok & any_valid;
    end

    // The pointer only advances on an accepted request, so a stalled winner
    // keeps the grant and mem_req_valid_o/addr stay stable.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_hs) begin
            rr_ptr_d = IDX_W'((32'(winner) + 32'd1) % NUM_REQ);
        end
    end

    // --------------------------------------------------------------- response
    always_comb begin
        rsp_valid_o       = '0;
        rsp_valid_o[head] = mem_rsp_valid_i & ~fifo_empty;
    end

    assign rsp_data_o  = mem_rsp_data_i;
    assign rsp_error_o = mem_rsp_error_i;

    // With nothing outstanding the response is swallowed (ready tracks valid)
    // and flagged as spurious instead of being routed anywhere.
    assign mem_rsp_ready_o = fifo_empty ? mem_rsp_valid_i : rsp_ready_i[head];
    assign rsp_pop         = mem_rsp_valid_i & ~fifo_empty & rsp_ready_i[head];
    assign spurious_d      = spurious_q | (mem_rsp_valid_i & fifo_empty);

    // Full is taken from the registered count, so a pop in the same cycle
    // does not open a slot for a push until the next cycle.
    mpt_id_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (IDX_W),
        .CNT_W  (CNT_W)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_hs),
        .push_data_i (winner),
        .pop_i       (rsp_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // ------------------------------------------------------------------ drain
    // No pushes happen outside RUN, so "empty after this cycle" only needs
    // the last entry being popped now.
    assign drain_empty = fifo_empty | ((fifo_count == CNT_W'(1)) & rsp_pop);

    always_comb begin
        state_d   = state_q;
        issue_ok  = 1'b0;
        drained_o = 1'b0;
        unique case (state_q)
            ARB_RUN: begin
                issue_ok = ~fifo_full;
                if (drain_i) begin
                    state_d = ARB_DRAINING;
                end
            end
            ARB_DRAINING: begin
                if (!drain_i) begin
                    state_d = ARB_RUN;
                end else if (drain_empty) begin
                    state_d = ARB_DRAINED;
                end
            end
            ARB_DRAINED: begin
                drained_o = 1'b1;
                if (!drain_i) begin
                    state_d = ARB_RUN;
                end
            end
            default: begin
                state_d = ARB_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_RUN;
            rr_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_rsp_o = spurious_q;

`ifdef MPT_ARB_PERF_CNT_EN
    // ------------------------------------------------------------ perf count
    localparam int unsigned PW = MPT_ARB_PERF_CNT_WIDTH;

    logic [NUM_REQ-1:0][PW-1:0] grant_cnt_q;
    logic [PW-1:0]              stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (req_hs && (winner == IDX_W'(k)) && (grant_cnt_q[k] != '1)) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + PW'(1);
                end
            end
            if (any_valid && fifo_full && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PW'(1);
            end
        end
    end

    assign perf_grant_cnt_o      = grant_cnt_q;
    assign perf_full_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mpt_walk_mem_arbiter.sv
module tb_mpt_walk_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [DW-1:0]     rsp_data, mem_rsp_data;
    logic              rsp_error, mem_req_valid, mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_rsp_valid, mem_rsp_ready, mem_rsp_error;
    logic              drain, drained, spurious;

    always #5 clk = ~clk;

    mpt_walk_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_error_o     (rsp_error),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_ready_o (mem_rsp_ready),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_error_i (mem_rsp_error),
        .drain_i         (drain),
        .drained_o       (drained),
        .spurious_rsp_o  (spurious)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          sb[$];          // expected requester index of each outstanding read
    int          m_ptr;
    bit          m_run;
    bit          exp_drained;
    bit          exp_spur;
    logic [AW-1:0] addr_tab [NR];

    typedef struct {
        logic [NR-1:0] v;
        logic          mr;
        logic          rv;
        logic          emv;
        logic [NR-1:0] erdy;
        logic [AW-1:0] eaddr;
        logic [NR-1:0] ersp;
    } vec_t;
    vec_t tab [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NR-1:0] v, input int p);
        int j;
        for (int i = 0; i < NR; i++) begin
            j = (p + i) % NR;
            if (v[j[1:0]]) return j;
        end
        return p;
    endfunction

    // One clock of stimulus with model-based expectations.
    task automatic do_cycle(input string nm, input logic [NR-1:0] v, input logic mr,
                            input logic rv, input logic [DW-1:0] rd, input logic re,
                            input logic [NR-1:0] rr);
        int            w;
        int            h;
        logic          emv;
        logic [NR-1:0] erdy;
        bit            spur_evt;
        req_valid     = v;
        mem_req_ready = mr;
        mem_rsp_valid = rv;
        mem_rsp_data  = rd;
        mem_rsp_error = re;
        rsp_ready     = rr;
        spur_evt      = 1'b0;
        #1;
        emv  = m_run && (sb.size() < MO) && (v != '0);
        w    = model_pick(v, m_ptr);
        erdy = (emv && mr) ? (4'b0001 << w) : 4'b0000;
        chk({nm, " mem_req_valid"}, 64'(mem_req_valid), 64'(emv));
        chk({nm, " req_ready"}, 64'(req_ready), 64'(erdy));
        if (emv) chk({nm, " mem_req_addr"}, mem_req_addr, addr_tab[w]);
        chk({nm, " drained"}, 64'(drained), 64'(exp_drained));
        chk({nm, " spurious"}, 64'(spurious), 64'(exp_spur));
        if (rv && sb.size() > 0) begin
            h = sb[0];
            chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(4'b0001 << h));
            chk({nm, " mem_rsp_ready"}, 64'(mem_rsp_ready), 64'(rr[h]));
            chk({nm, " rsp_data"}, rsp_data, rd);
            chk({nm, " rsp_error"}, 64'(rsp_error), 64'(re));
            if (rr[h]) void'(sb.pop_front());
        end else if (rv) begin
            chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd0);
            chk({nm, " mem_rsp_ready"}, 64'(mem_rsp_ready), 64'd1);
            spur_evt = 1'b1;
        end else begin
            chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        end
        if (erdy != '0) begin
            sb.push_back(w);
            m_ptr = (w + 1) % NR;
        end
        tick();
        if (spur_evt) exp_spur = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        addr_tab = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};
        req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

        // Rotation/arbitration vectors, starting from reset (ptr 0, FIFO empty).
        // Each row answers the read issued in the row before it.
        //          v      mr    rv    emv   erdy     eaddr       ersp
        tab[0]  = '{4'hF,  1'b1, 1'b0, 1'b1, 4'b0001, 64'h1000, 4'b0000};
        tab[1]  = '{4'hF,  1'b1, 1'b1, 1'b1, 4'b0010, 64'h2000, 4'b0001};
        tab[2]  = '{4'hF,  1'b1, 1'b1, 1'b1, 4'b0100, 64'h3000, 4'b0010};
        tab[3]  = '{4'hF,  1'b1, 1'b1, 1'b1, 4'b1000, 64'h4000, 4'b0100};
        tab[4]  = '{4'hF,  1'b1, 1'b1, 1'b1, 4'b0001, 64'h1000, 4'b1000};
        tab[5]  = '{4'h0,  1'b1, 1'b1, 1'b0, 4'b0000, 64'h0,    4'b0001};
        tab[6]  = '{4'hA,  1'b1, 1'b0, 1'b1, 4'b0010, 64'h2000, 4'b0000};
        tab[7]  = '{4'hA,  1'b1, 1'b1, 1'b1, 4'b1000, 64'h4000, 4'b0010};
        tab[8]  = '{4'h5,  1'b1, 1'b1, 1'b1, 4'b0001, 64'h1000, 4'b1000};
        tab[9]  = '{4'h4,  1'b0, 1'b1, 1'b1, 4'b0000, 64'h3000, 4'b0001};
        tab[10] = '{4'h4,  1'b1, 1'b0, 1'b1, 4'b0100, 64'h3000, 4'b0000};
        tab[11] = '{4'h0,  1'b1, 1'b1, 1'b0, 4'b0000, 64'h0,    4'b0100};

        // Reset
        rst = 1'b1; drain = 1'b0;
        req_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_data = '0; mem_rsp_error = 1'b0; rsp_ready = '0;
        m_ptr = 0; m_run = 1'b1; exp_drained = 1'b0; exp_spur = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset mem_req_addr", mem_req_addr, 64'd0);
        chk("reset mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset rsp_error", 64'(rsp_error), 64'd0);
        chk("reset drained", 64'(drained), 64'd0);
        chk("reset spurious", 64'(spurious), 64'd0);
        tick();

        // Table-driven rotation
        for (int i = 0; i < 12; i++) begin
            req_valid     = tab[i].v;
            mem_req_ready = tab[i].mr;
            mem_rsp_valid = tab[i].rv;
            mem_rsp_data  = 64'h0000_0000_0000_D000 + 64'(i);
            mem_rsp_error = 1'b0;
            rsp_ready     = 4'hF;
            #1;
            chk($sformatf("vec%0d mem_req_valid", i), 64'(mem_req_valid), 64'(tab[i].emv));
            chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(tab[i].erdy));
            if (tab[i].emv) chk($sformatf("vec%0d mem_req_addr", i), mem_req_addr, tab[i].eaddr);
            chk($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(tab[i].ersp));
            if (tab[i].rv) begin
                chk($sformatf("vec%0d rsp_data", i), rsp_data, 64'h0000_0000_0000_D000 + 64'(i));
                chk($sformatf("vec%0d mem_rsp_ready", i), 64'(mem_rsp_ready), 64'd1);
                if (sb.size() > 0) begin
                    chk($sformatf("vec%0d rsp route", i), 64'(rsp_valid), 64'(4'b0001 << sb[0]));
                    void'(sb.pop_front());
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (tab[i].erdy[k]) begin
                    sb.push_back(k);
                    m_ptr = (k + 1) % NR;
                end
            end
            tick();
        end

        // Fill the ID FIFO, stall on full, resume the cycle after a pop
        for (int i = 0; i < MO; i++) do_cycle("fill", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("full stall", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("full pop", 4'hF, 1'b1, 1'b1, 64'h55, 1'b0, 4'hF);
        do_cycle("full resume", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        for (int i = 0; i < MO; i++) do_cycle("flush", 4'h0, 1'b0, 1'b1, 64'h60 + 64'(i), 1'b0, 4'hF);

        // Response routing with backpressure from requester 2
        do_cycle("route issue2", 4'b0100, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("route issue0", 4'b0001, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) do_cycle("route hold", 4'h0, 1'b0, 1'b1, 64'hAA, 1'b0, 4'b1011);
        do_cycle("route rsp2", 4'h0, 1'b0, 1'b1, 64'hAA, 1'b0, 4'hF);
        do_cycle("route rsp0", 4'h0, 1'b0, 1'b1, 64'hBB, 1'b1, 4'hF);

        // Drain with two reads outstanding
        do_cycle("drain issue", 4'b0011, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("drain issue", 4'b0011, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        drain = 1'b1;
        do_cycle("drain req", 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        m_run = 1'b0;
        do_cycle("draining idle", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("draining rsp1", 4'hF, 1'b1, 1'b1, 64'h71, 1'b0, 4'hF);
        do_cycle("draining rsp2", 4'hF, 1'b1, 1'b1, 64'h72, 1'b0, 4'hF);
        exp_drained = 1'b1;
        do_cycle("drained", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);
        drain = 1'b0;
        do_cycle("undrain", 4'hF, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        exp_drained = 1'b0; m_run = 1'b1;
        do_cycle("rerun", 4'hF, 1'b0, 1'b0, '0, 1'b0, 4'hF);

        // Drain while a request is stalled: valid drops the next cycle
        drain = 1'b1;
        do_cycle("stall drain", 4'hF, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        m_run = 1'b0;
        do_cycle("stall dropped", 4'hF, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        exp_drained = 1'b1; drain = 1'b0;
        do_cycle("stall drained", 4'h0, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        exp_drained = 1'b0; m_run = 1'b1;

        // Spurious response with empty FIFO, sticky until reset
        do_cycle("spurious rsp", 4'h0, 1'b0, 1'b1, 64'hEE, 1'b0, 4'h0);
        do_cycle("spurious sticky", 4'h0, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        do_cycle("spurious sticky", 4'h0, 1'b0, 1'b0, '0, 1'b0, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_ptr = 0; exp_spur = 1'b0;
        #1;
        chk("spurious cleared", 64'(spurious), 64'd0);
        do_cycle("post reset", 4'hF, 1'b1, 1'b0, '0, 1'b0, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
